// File: rtl/rectangle_pkg.sv
// Shared RECTANGLE constants: S-box table, round-constant LFSR, key-state geometry.
// Pure definitions; no latency and no flow control.
package rectangle_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } ks_state_t;

    localparam int RND_W = 5;
    localparam int RC_W  = 5;

    localparam logic [RC_W-1:0] RC_INIT   = 5'h01;
    localparam int              RC_TAP_HI = 4;
    localparam int              RC_TAP_LO = 2;

    // Nibble i of the table is S[i]: S = {6,5,C,A,1,E,7,9,B,0,3,D,8,F,4,2}
    localparam logic [63:0] SBOX_TAB = 64'h24F8_D30B_97E1_AC56;

    localparam int ROW_W_80   = 16;
    localparam int ROW_W_128  = 32;
    localparam int NROWS_80   = 5;
    localparam int NROWS_128  = 4;
    localparam int NCOL_80    = 4;
    localparam int NCOL_128   = 8;

    function automatic logic [RC_W-1:0] rc_next(input logic [RC_W-1:0] rc);
        return {rc[RC_W-2:0], rc[RC_TAP_HI] ^ rc[RC_TAP_LO]};
    endfunction

    function automatic logic [3:0] sbox_lookup(input logic [3:0] nib);
        return SBOX_TAB[{nib, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/rectangle_sbox.sv
// 4-bit RECTANGLE S-box, shared by the key schedule and the round datapath.
// Purely combinational: zero latency, no flow control.
module rectangle_sbox
    import rectangle_pkg::*;
(
    input  logic [3:0] nib,
    output logic [3:0] sub
);

    assign sub = sbox_lookup(nib);

endmodule

// File: rtl/rectangle_key_sched.sv
// RECTANGLE key schedule for 80/128-bit keys with stored master key for rewind.
// Load/restart/next take effect at the next edge; no backpressure, the round controller paces i_next.
module rectangle_key_sched
    import rectangle_pkg::*;
#(
    parameter int KEY_W  = 80,
    parameter int ROUNDS = 25
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [KEY_W-1:0] iv_key,
    input  logic             i_restart,
    input  logic             i_next,
    output logic [63:0]      ov_rkey,
    output logic             o_valid,
    output logic             o_last,
    output logic [RND_W-1:0] ov_round
);

    localparam bit IS128 = (KEY_W == 128);
    localparam int ROW_W = IS128 ? ROW_W_128 : ROW_W_80;
    localparam int NROWS = IS128 ? NROWS_128 : NROWS_80;
    localparam int NCOL  = IS128 ? NCOL_128  : NCOL_80;

    localparam logic [RND_W-1:0] LAST_RND = RND_W'(ROUNDS);

    if (KEY_W != 80 && KEY_W != 128) begin : g_bad_key_w
        $error("rectangle_key_sched: KEY_W must be 80 or 128");
    end
    if (ROUNDS < 1 || ROUNDS > 31) begin : g_bad_rounds
        $error("rectangle_key_sched: ROUNDS must fit the 5-bit round index");
    end

    function automatic logic [ROW_W-1:0] rotl(input logic [ROW_W-1:0] x, input int unsigned n);
        return (x << n) | (x >> (ROW_W - n));
    endfunction

    ks_state_t        state_q, state_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic [KEY_W-1:0] master_q, master_d;
    logic [RND_W-1:0] round_q, round_d;
    logic [RC_W-1:0]  rc_q, rc_d;

    logic [NROWS-1:0][ROW_W-1:0] row, srow, mix;
    logic [KEY_W-1:0]            key_nxt;

    assign row = key_q;

    // S-box layer: column c is the nibble {row3[c],row2[c],row1[c],row0[c]}
    for (genvar c = 0; c < NCOL; c++) begin : g_sbox
        logic [3:0] col_nib, col_sub;
        assign col_nib = {row[3][c], row[2][c], row[1][c], row[0][c]};
        rectangle_sbox u_sbox (
            .nib (col_nib),
            .sub (col_sub)
        );
        for (genvar r = 0; r < 4; r++) begin : g_bit
            assign srow[r][c] = col_sub[r];
        end
    end

    for (genvar r = 0; r < NROWS; r++) begin : g_pass
        if (r < 4) begin : g_upper
            assign srow[r][ROW_W-1:NCOL] = row[r][ROW_W-1:NCOL];
        end else begin : g_whole
            assign srow[r] = row[r];
        end
    end

    if (IS128) begin : g_mix128
        assign mix[0] = rotl(srow[0], 8) ^ srow[1];
        assign mix[1] = srow[2];
        assign mix[2] = rotl(srow[2], 16) ^ srow[3];
        assign mix[3] = srow[0];
    end else begin : g_mix80
        assign mix[0] = rotl(srow[0], 8) ^ srow[1];
        assign mix[1] = srow[2];
        assign mix[2] = srow[3];
        assign mix[3] = rotl(srow[3], 12) ^ srow[4];
        assign mix[4] = srow[0];
    end

    // Round constant lands in the low five bits of the new row 0
    assign key_nxt = mix ^ KEY_W'(rc_q);

    assign ov_rkey  = {row[3][15:0], row[2][15:0], row[1][15:0], row[0][15:0]};
    assign ov_round = round_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            key_q    <= '0;
            master_q <= '0;
            round_q  <= '0;
            rc_q     <= RC_INIT;
        end else begin
            state_q  <= state_d;
            key_q    <= key_d;
            master_q <= master_d;
            round_q  <= round_d;
            rc_q     <= rc_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        key_d    = key_q;
        master_d = master_q;
        round_d  = round_q;
        rc_d     = rc_q;
        o_valid  = 1'b0;
        o_last   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Restart and next are meaningless until a master key exists
                if (i_load) begin
                    state_d  = ST_RUN;
                    key_d    = iv_key;
                    master_d = iv_key;
                    round_d  = '0;
                    rc_d     = RC_INIT;
                end
            end
            ST_RUN: begin
                o_valid = 1'b1;
                o_last  = (round_q == LAST_RND);
                if (i_load) begin
                    key_d    = iv_key;
                    master_d = iv_key;
                    round_d  = '0;
                    rc_d     = RC_INIT;
                end else if (i_restart) begin
                    key_d   = master_q;
                    round_d = '0;
                    rc_d    = RC_INIT;
                end else if (i_next && round_q != LAST_RND) begin
                    key_d   = key_nxt;
                    round_d = round_q + RND_W'(1);
                    rc_d    = rc_next(rc_q);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_rectangle_key_sched.sv
// Random-key bench for rectangle_key_sched: 80- and 128-bit instances share controls
// and are compared every cycle against a row-array reference model.
module tb_rectangle_key_sched;

    localparam int ROUNDS = 25;

    logic         i_clk = 1'b0;
    logic         i_rst_n;
    logic         i_load, i_restart, i_next;
    logic [79:0]  key80;
    logic [127:0] key128;
    logic [63:0]  rk80, rk128;
    logic         v80, v128, l80, l128;
    logic [4:0]   rd80, rd128;

    int n_tests = 0;
    int n_fail  = 0;

    int sb_tab [16] = '{6, 5, 12, 10, 1, 14, 7, 9, 11, 0, 3, 13, 8, 15, 4, 2};

    logic         m_run;
    int           m_round;
    int           m_rc;
    logic [127:0] m_st80, m_mst80, m_st128, m_mst128;

    always #5 i_clk = ~i_clk;

    rectangle_key_sched #(.KEY_W(80), .ROUNDS(ROUNDS)) u_dut80 (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_load    (i_load),
        .iv_key    (key80),
        .i_restart (i_restart),
        .i_next    (i_next),
        .ov_rkey   (rk80),
        .o_valid   (v80),
        .o_last    (l80),
        .ov_round  (rd80)
    );

    rectangle_key_sched #(.KEY_W(128), .ROUNDS(ROUNDS)) u_dut128 (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_load    (i_load),
        .iv_key    (key128),
        .i_restart (i_restart),
        .i_next    (i_next),
        .ov_rkey   (rk128),
        .o_valid   (v128),
        .o_last    (l128),
        .ov_round  (rd128)
    );

    function automatic longint unsigned rot(input longint unsigned x, input int n, input int w);
        longint unsigned mask = (64'd1 << w) - 64'd1;
        return ((x << n) | (x >> (w - n))) & mask;
    endfunction

    function automatic int lfsr_adv(input int rc);
        return ((rc << 1) & 31) | (((rc >> 4) ^ (rc >> 2)) & 1);
    endfunction

    function automatic logic [127:0] ref_step(input logic [127:0] k, input int kw, input int rc);
        int nr = (kw == 80) ? 5 : 4;
        int w = kw / nr;
        int ncol = (kw == 80) ? 4 : 8;
        longint unsigned mask = (64'd1 << w) - 64'd1;
        longint unsigned r [5];
        longint unsigned n [5];
        logic [127:0] res = '0;
        for (int i = 0; i < 5; i++) begin
            r[i] = (i < nr) ? (64'(k >> (i * w)) & mask) : 64'd0;
            n[i] = 64'd0;
        end
        for (int c = 0; c < ncol; c++) begin
            int v = 0;
            for (int i = 0; i < 4; i++) v = v | (int'((r[i] >> c) & 64'd1) << i);
            v = sb_tab[v];
            for (int i = 0; i < 4; i++)
                r[i] = (r[i] & ~(64'd1 << c)) | (64'((v >> i) & 1) << c);
        end
        n[0] = rot(r[0], 8, w) ^ r[1] ^ 64'(rc);
        if (kw == 80) begin
            n[1] = r[2];
            n[2] = r[3];
            n[3] = rot(r[3], 12, w) ^ r[4];
            n[4] = r[0];
        end else begin
            n[1] = r[2];
            n[2] = rot(r[2], 16, w) ^ r[3];
            n[3] = r[0];
        end
        for (int i = 0; i < nr; i++) res = res | (128'(n[i]) << (i * w));
        return res;
    endfunction

    function automatic logic [63:0] ref_rkey(input logic [127:0] k, input int kw);
        int w = (kw == 80) ? 16 : 32;
        logic [63:0] rk = '0;
        for (int i = 0; i < 4; i++) rk[16*i +: 16] = k[i*w +: 16];
        return rk;
    endfunction

    function automatic logic [79:0] rnd80();
        return {16'($urandom), $urandom, $urandom};
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic compare_all(input string tag);
        logic exp_last;
        exp_last = m_run && (m_round == ROUNDS);
        chk({tag, "/rk80"},   128'(rk80),  128'(ref_rkey(m_st80, 80)));
        chk({tag, "/v80"},    128'(v80),   128'(m_run));
        chk({tag, "/last80"}, 128'(l80),   128'(exp_last));
        chk({tag, "/rd80"},   128'(rd80),  128'(m_round));
        chk({tag, "/rk128"},  128'(rk128), 128'(ref_rkey(m_st128, 128)));
        chk({tag, "/v128"},   128'(v128),  128'(m_run));
        chk({tag, "/last128"},128'(l128),  128'(exp_last));
        chk({tag, "/rd128"},  128'(rd128), 128'(m_round));
    endtask

    task automatic model_reset();
        m_run   = 1'b0;
        m_round = 0;
        m_rc    = 1;
        m_st80  = '0;
        m_mst80 = '0;
        m_st128 = '0;
        m_mst128 = '0;
    endtask

    task automatic tick(input logic ld, input logic rs, input logic nx,
                        input logic [79:0] k80, input logic [127:0] k128, input string tag);
        i_load    = ld;
        i_restart = rs;
        i_next    = nx;
        key80     = k80;
        key128    = k128;
        @(posedge i_clk);
        #1;
        if (ld) begin
            m_st80   = 128'(k80);
            m_mst80  = 128'(k80);
            m_st128  = k128;
            m_mst128 = k128;
            m_run    = 1'b1;
            m_round  = 0;
            m_rc     = 1;
        end else if (m_run && rs) begin
            m_st80  = m_mst80;
            m_st128 = m_mst128;
            m_round = 0;
            m_rc    = 1;
        end else if (m_run && nx && m_round < ROUNDS) begin
            m_st80  = ref_step(m_st80, 80, m_rc);
            m_st128 = ref_step(m_st128, 128, m_rc);
            m_round++;
            m_rc = lfsr_adv(m_rc);
        end
        i_load    = 1'b0;
        i_restart = 1'b0;
        i_next    = 1'b0;
        compare_all(tag);
    endtask

    task automatic advance(input int n, input string tag);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b1, key80, key128, tag);
    endtask

    initial begin
        logic [79:0]  k80;
        logic [127:0] k128;

        i_rst_n = 1'b0;
        i_load = 1'b0;
        i_restart = 1'b0;
        i_next = 1'b0;
        key80 = '0;
        key128 = '0;
        model_reset();
        #2;
        compare_all("reset");
        #20;
        i_rst_n = 1'b1;

        // Zero key: hand-derived K1 values for both widths
        tick(1'b1, 1'b0, 1'b0, '0, '0, "t1_load");
        chk("t1_k0", 128'(rk80), 128'(64'h0));
        tick(1'b0, 1'b0, 1'b1, '0, '0, "t1_next");
        chk("t1_k1_80", 128'(rk80), 128'(64'h0000_0000_000F_000E));
        chk("t1_k1_128", 128'(rk128), 128'(64'h0000_0000_00FF_00FE));

        // Full schedule, then one extra next at the last round
        tick(1'b1, 1'b0, 1'b0, rnd80(), rnd128(), "t2_load");
        advance(ROUNDS, "t2_run");
        chk("t2_last", 128'(l80), 128'(1'b1));
        tick(1'b0, 1'b0, 1'b1, key80, key128, "t2_hold");
        chk("t2_hold_rd", 128'(rd80), 128'(ROUNDS));

        // Rewind from round 7 and replay all round keys
        tick(1'b1, 1'b0, 1'b0, rnd80(), rnd128(), "t3_load");
        advance(7, "t3_pre");
        tick(1'b0, 1'b1, 1'b0, key80, key128, "t3_restart");
        chk("t3_rd0", 128'(rd80), 128'(0));
        advance(ROUNDS, "t3_replay");

        // Control priorities
        advance(0, "t4");
        tick(1'b0, 1'b1, 1'b0, key80, key128, "t4_rw");
        advance(12, "t4_pre");
        tick(1'b1, 1'b0, 1'b1, rnd80(), rnd128(), "t4_load_next");
        advance(3, "t4_mid");
        tick(1'b0, 1'b1, 1'b1, key80, key128, "t4_restart_next");
        advance(2, "t4_post");

        // Asynchronous reset mid-cycle at round 10
        tick(1'b1, 1'b0, 1'b0, rnd80(), rnd128(), "t5_load");
        advance(10, "t5_pre");
        @(posedge i_clk);
        #3;
        i_rst_n = 1'b0;
        model_reset();
        #1;
        compare_all("t5_async");
        #10;
        i_rst_n = 1'b1;
        tick(1'b0, 1'b0, 1'b1, key80, key128, "t5_next_idle");
        tick(1'b0, 1'b1, 1'b0, key80, key128, "t5_rst_idle");
        tick(1'b0, 1'b1, 1'b1, key80, key128, "t5_both_idle");
        tick(1'b1, 1'b0, 1'b0, rnd80(), rnd128(), "t5_reload");
        advance(2, "t5_post");

        // Bulk random keys, starting with all-zeros and all-ones
        for (int n = 0; n < 1000; n++) begin
            if (n == 0) begin
                k80 = '0;
                k128 = '0;
            end else if (n == 1) begin
                k80 = '1;
                k128 = '1;
            end else begin
                k80 = rnd80();
                k128 = rnd128();
            end
            tick(1'b1, 1'b0, 1'b0, k80, k128, "t6_load");
            advance(ROUNDS, "t6_run");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rectangle_key_sched.md
Name: rectangle_key_sched

Overview:
- Parametrised, round-based RECTANGLE key-schedule register; successor to the fixed 80-bit key register with external mux.
- Holds the key state for 80- or 128-bit keys and applies the RECTANGLE key update internally.
- Keeps a copy of the master key so the schedule can rewind for the next block without re-loading.
- Presents one 64-bit round key per cycle to the round datapath; the round controller drives it.

Parameters:
- KEY_W, 80, master key width; legal values 80 or 128 only; any other value is a elaboration error.
- ROUNDS, 25, number of update steps; round keys K0..K_ROUNDS are produced.

Ports:
- i_clk  input  1  rising-edge clock
- i_rst_n  input  1  asynchronous active-low reset
- i_load  input  1  load iv_key as master key and current state
- iv_key  input  KEY_W  master key
- i_restart  input  1  reload current state from the stored master key
- i_next  input  1  advance the schedule one round
- ov_rkey  output  64  current round key
- o_valid  output  1  ov_rkey holds a valid round key
- o_last  output  1  ov_rkey is K_ROUNDS
- ov_round  output  5  index of the current round key, 0..ROUNDS

Behaviour:
- State representation:
  - KEY_W=80: 5 rows of 16 bits, row r = key[16r+15:16r].
  - KEY_W=128: 4 rows of 32 bits, row r = key[32r+31:32r].
- Round key output: ov_rkey = {row3[15:0], row2[15:0], row1[15:0], row0[15:0]}. It is combinational from the state register, so it is valid in the same cycle o_valid=1.
- Update step applied on i_next:
  - S-box step: apply S-box S = {6,5,C,A,1,E,7,9,B,0,3,D,8,F,4,2}. Apply it to columns 0..3 for 80-bit keys and columns 0..7 for 128-bit keys. The column nibble is {row3[c], row2[c], row1[c], row0[c]}, with row0 as the LSB.
  - Row mix, 80-bit: r0'=(r0<<<8)^r1, r1'=r2, r2'=r3, r3'=(r3<<<12)^r4, r4'=r0.
  - Row mix, 128-bit: r0'=(r0<<<8)^r1, r1'=r2, r2'=(r2<<<16)^r3, r3'=r0.
  - Constant step: XOR rc[4:0] into r0'[4:0].
- Round constant: 5-bit LFSR, value 5'h01 at round 0; next = {rc[3:0], rc[4]^rc[2]}. The LFSR is reset to 5'h01 on load and on restart.
- Reset: all registers clear; ov_rkey=0, o_valid=0, o_last=0, ov_round=0, rc=5'h01. Reset takes effect immediately and aborts any schedule in progress.
- State machine:
  - IDLE: o_valid=0.
  - i_load → RUN with round 0, 1-cycle latency.
  - RUN: o_valid=1; i_next with round<ROUNDS advances round by 1.
  - At round=ROUNDS, o_last=1 and i_next is ignored; the state holds, no wrap.
- i_restart:
  - Legal only once a master key has been loaded; in IDLE with no master key ever loaded it is ignored.
  - Otherwise the state, round and rc return to their round-0 values in 1 cycle.
- Priority when controls are asserted together: i_load > i_restart > i_next. For example, load and next in the same cycle produce K0.
- i_next in IDLE is ignored.

Decomposition:
- Shared package rectangle_pkg:
  - S-box constant table.
  - RC LFSR initial value 5'h01 and tap definition.
  - Round-count width (5 bits).
  - Row widths per key size.
- Sub-module rectangle_sbox: 4-bit combinational S-box, instantiated 4 or 8 times via generate. The same sub-module is reused by the data path.

Test Plan:
1. KEY_W=80, reset, then load key 0, then one i_next → cycle after load: ov_rkey=64'h0, ov_round=0; after next: ov_rkey=64'h0000_0000_000F_000E, ov_round=1.
2. KEY_W=80, load, then 25 consecutive i_next → o_last=1 at ov_round=25. A 26th i_next leaves ov_rkey, ov_round and o_last unchanged. The rc sequence matches the LFSR model: 01,02,04,09,12,...
3. Load random key, advance to round 7, pulse i_restart → next cycle ov_round=0 and ov_rkey equals the loaded key's low 16 bits of each row. A second run reproduces identical K1..K25.
4. Simultaneous i_load+i_next at round 12 → round 0 with the new key. Simultaneous i_restart+i_next → round 0.
5. Deassert i_rst_n asynchronously mid-cycle at round 10 → outputs clear immediately, not at the next edge. After reset release, i_next and i_restart are ignored until i_load.
6. KEY_W=128, random keys → all 26 round keys match the reference model over 1000 keys, including all-ones and all-zeros keys.
